// File: rtl/stream_pkg.sv
// Shared definitions for the stream IP family.
// Contents:
//   ptr_width()    - width of a FIFO read/write pointer (one wrap bit above the address)
//   fifo_status_t  - fill-level/almost-full bundle for stream IPs that report status
package stream_pkg;

  localparam int unsigned StatusLevelW = 16;

  typedef struct packed {
    logic [StatusLevelW-1:0] level;
    logic                    almost_full;
  } fifo_status_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_channel.sv
// AXI-Stream channel bundle.
// Parameters set field widths; t_strb/t_keep are one bit per data byte.
// Modports:
//   slave  - receives beats (drives t_ready)
//   master - sends beats (drives t_valid and payload)
interface stream_channel #(
  parameter int unsigned IdW   = 4,
  parameter int unsigned DestW = 4,
  parameter int unsigned DataW = 32,
  parameter int unsigned UserW = 4
);
  localparam int unsigned StrbW = DataW / 8;

  // Full beat as stored by buffering IPs.
  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DestW-1:0] dest;
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic [StrbW-1:0] keep;
    logic             last;
    logic [UserW-1:0] user;
  } pack_t;

  logic             t_valid;
  logic             t_ready;
  logic [IdW-1:0]   t_id;
  logic [DestW-1:0] t_dest;
  logic [DataW-1:0] t_data;
  logic [StrbW-1:0] t_strb;
  logic [StrbW-1:0] t_keep;
  logic             t_last;
  logic [UserW-1:0] t_user;

  modport slave (
    input  t_valid, t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user,
    output t_ready
  );

  modport master (
    output t_valid, t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user,
    input  t_ready
  );

endinterface

// File: rtl/stream_fifo_ram.sv
// Storage array for stream_fifo.
// Synchronous write, asynchronous read, contents are not reset.
// Ports:
//   clk_i    - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write word
//   raddr_i  - read address
//   rdata_o  - read word (combinational)
module stream_fifo_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// AXI-Stream FIFO, first-word-fall-through, between slave channel s and master channel m.
// Optional store-and-forward mode: define STREAM_FIFO_PACKET_MODE_EN. In that mode m.t_valid
// is held low until a complete packet (t_last) is stored, or the FIFO is full.
// Ports:
//   clk          - clock for both channels
//   rstn         - asynchronous active-low reset; discards all stored beats
//   s            - upstream channel (slave)
//   m            - downstream channel (master), same widths as s
//   level        - number of stored beats (0..DEPTH)
//   almost_full  - level >= ALMOST_FULL_LEVEL
module stream_fifo
  import stream_pkg::*;
#(
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  stream_channel.slave             s,
  stream_channel.master            m,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PtrW  = ptr_width(DEPTH);
  localparam int unsigned IdW   = $bits(s.t_id);
  localparam int unsigned DestW = $bits(s.t_dest);
  localparam int unsigned DataW = $bits(s.t_data);
  localparam int unsigned StrbW = $bits(s.t_strb);
  localparam int unsigned KeepW = $bits(s.t_keep);
  localparam int unsigned UserW = $bits(s.t_user);

  // Same field layout as the channel's pack_t.
  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DestW-1:0] dest;
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic [KeepW-1:0] keep;
    logic             last;
    logic [UserW-1:0] user;
  } pack_t;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $fatal(1, "stream_fifo: DEPTH must be a power of two >= 2");
  end
  if ((ALMOST_FULL_LEVEL < 1) || (ALMOST_FULL_LEVEL > DEPTH)) begin : gen_bad_af
    $fatal(1, "stream_fifo: ALMOST_FULL_LEVEL must be in 1..DEPTH");
  end
  if ((IdW != $bits(m.t_id)) || (DestW != $bits(m.t_dest)) || (DataW != $bits(m.t_data)) ||
      (StrbW != $bits(m.t_strb)) || (KeepW != $bits(m.t_keep)) ||
      (UserW != $bits(m.t_user))) begin : gen_bad_width
    $fatal(1, "stream_fifo: s and m channel widths differ");
  end

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] level_q, level_d;
  logic            ready_q, ready_d;
  logic            almost_full_q, almost_full_d;
  logic            empty, full, full_d;
  logic            m_valid;
  logic            push, pop;
  pack_t           wdata, rdata;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Ready is a registered copy of !full so s.t_ready never depends on m.t_ready.
  assign push = s.t_valid && ready_q;
  assign pop  = m_valid && m.t_ready;

`ifdef STREAM_FIFO_PACKET_MODE_EN
  logic [PtrW-1:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({push && s.t_last, pop && rdata.last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // The full override releases packets longer than the FIFO, which would otherwise deadlock.
  assign m_valid = !empty && ((pkt_cnt_q != '0) || full);
`else
  assign m_valid = !empty;
`endif

  always_comb begin
    wr_ptr_d      = wr_ptr_q + PtrW'(push);
    rd_ptr_d      = rd_ptr_q + PtrW'(pop);
    level_d       = wr_ptr_d - rd_ptr_d;
    full_d        = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    ready_d       = !full_d;
    almost_full_d = (32'(level_d) >= ALMOST_FULL_LEVEL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      ready_q       <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      ready_q       <= ready_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign wdata = '{
    id:   s.t_id,
    dest: s.t_dest,
    data: s.t_data,
    strb: s.t_strb,
    keep: s.t_keep,
    last: s.t_last,
    user: s.t_user
  };

  stream_fifo_ram #(
    .Depth (DEPTH),
    .Width ($bits(pack_t)),
    .AddrW (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  assign s.t_ready   = ready_q;
  assign m.t_valid   = m_valid;
  assign m.t_id      = rdata.id;
  assign m.t_dest    = rdata.dest;
  assign m.t_data    = rdata.data;
  assign m.t_strb    = rdata.strb;
  assign m.t_keep    = rdata.keep;
  assign m.t_last    = rdata.last;
  assign m.t_user    = rdata.user;
  assign level       = level_q;
  assign almost_full = almost_full_q;

endmodule
